piece_bag_sampler: RTL and testbench
====================================

// Module: piece_bag_sampler
// PURPOSE
//  Consumer end of the random-bit stream: samples the serial LFSR output one bit per cycle and turns it
//  into tetromino IDs 0..6 under a 7-bag rule. Every 7 accepted pieces form a permutation of 0..6.
//  Uses rejection sampling with a bounded fallback, so a piece is always produced in bounded time.
//  Sits between the LFSR and the game controller's spawn logic; output is a valid/ready stream.
// PARAMETERS
//  MAX_REJECTS  8  consecutive rejected candidates before forced fallback to the lowest unused ID (>=1)
// PORTS
//  clk            in   1  clock
//  reset_n        in   1  asynchronous, active-low reset
//  rand_bit       in   1  serial random bit from LFSR; sampled only in COLLECT
//  flush          in   1  synchronous new-game clear; highest priority after reset
//  piece_ready    in   1  consumer accepts piece this cycle
//  piece_valid    out  1  piece_id holds an offered piece
//  piece_id       out  3  tetromino ID 0..6 (tetris_pkg::piece_t); never 7 while valid
//  bag_remaining  out  3  unused IDs left in the current bag, 7..1
// BEHAVIOUR
//  Reset values: state=COLLECT, cand=0, bit_cnt=0, reject_cnt=0, used_mask=7'b0,
//   piece_valid=0, piece_id=0, bag_remaining=7.
//  COLLECT: each cycle cand <= {cand[1:0], rand_bit}; bit_cnt++. After the 3rd bit, go to CHECK.
//  CHECK (1 cycle), mutually exclusive outcomes:
//   - cand<7 && !used_mask[cand]: piece_id<=cand; go to OFFER.
//   - else if reject_cnt==MAX_REJECTS-1: piece_id<=lowest index with used_mask==0; go to OFFER.
//   - else: reject_cnt++; bit_cnt<=0; go to COLLECT.
//  OFFER: piece_valid=1. piece_id is held stable until the handshake (valid&&ready); rand_bit is ignored.
//   On handshake: set used_mask[piece_id]; if the mask then reaches 7'h7F, clear it to 0 in the same edge;
//   reject_cnt<=0, bit_cnt<=0; go to COLLECT; piece_valid is low on the next cycle.
//  piece_valid is a registered state decode (state==OFFER); no combinational path from ready to valid.
//  bag_remaining = 7 - popcount(used_mask), driven combinationally from the register.
//  Latency: after a handshake at edge N, valid is low for >=4 cycles and rises at edge N+4 at the earliest.
//   Worst case: 4*MAX_REJECTS cycles.
//  Bag wrap: the 7th handshake of a bag returns bag_remaining to 7 on the next cycle.
//  flush=1: state=COLLECT, cand/bit_cnt/reject_cnt/used_mask cleared, valid low next cycle.
//   flush together with a handshake: flush wins and the offered piece is not recorded as used.
//  Reset mid-operation (any state): immediate return to reset values; any in-flight candidate is dropped.
// STRUCTURE
//  tetris_pkg:
//   - typedef enum logic [2:0] piece_t {I,O,T,S,Z,J,L} = 0..6;
//   - localparam NUM_PIECES=7;
//   - typedef enum state_t {COLLECT,CHECK,OFFER}.
//  Sub-module lowest_unused_picker: 7-bit used mask -> 3-bit index of the lowest clear bit.
//   Pure combinational priority encoder; its input is never all-ones.
//  Top module holds the FSM, shift register, counters and mask.
// TESTING
//  1 Reset; rand_bit 0,1,1 -> piece_valid rises 4 cycles after reset release, piece_id=3,
//    bag_remaining=7; ready=1 -> bag_remaining=6 and valid=0 on the next cycle.
//  2 rand_bit held 1 (cand always 7), MAX_REJECTS=8 -> after 32 cycles piece_id=0 (fallback);
//    accept it; the next fallback gives piece_id=1.
//  3 Random bit stream, ready=1: 21 pieces -> each group of 7 is a permutation of 0..6;
//    bag_remaining steps 7,6,..,1,7.
//  4 After accepting ID 3, feed 0,1,1 -> rejected (no valid); then 1,0,1 -> piece_id=5.
//  5 Hold ready=0 for 20 cycles in OFFER with toggling rand_bit -> piece_id and valid stable;
//    the next candidate is built only from bits sampled after the handshake.
//  6 flush and ready both high in OFFER -> valid=0 next cycle, bag_remaining=7;
//    reset_n low mid-COLLECT -> all outputs at reset values.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types for the piece generator: tetromino IDs, bag size and sampler FSM states.
package tetris_pkg;

    typedef enum logic [2:0] {
        I = 3'd0,
        O = 3'd1,
        T = 3'd2,
        S = 3'd3,
        Z = 3'd4,
        J = 3'd5,
        L = 3'd6
    } piece_t;

    localparam int NUM_PIECES = 7;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CHECK   = 2'd1,
        OFFER   = 2'd2
    } state_t;

endpackage

// File: rtl/lowest_unused_picker.sv
// Priority encoder: index of the lowest clear bit in the bag's used mask.
// The mask is never all-ones when this result is consumed.
module lowest_unused_picker
    import tetris_pkg::*;
(
    input  logic [NUM_PIECES-1:0] i_used_mask,
    output logic [2:0]            o_idx
);

    // Scan from the top down so the lowest clear bit is the last one written
    always_comb begin
        o_idx = '0;
        for (int unsigned i = NUM_PIECES; i > 0; i--) begin
            if (!i_used_mask[i-1]) begin
                o_idx = 3'(i - 1);
            end
        end
    end

endmodule

// File: rtl/piece_bag_sampler.sv
// 7-bag tetromino sampler: assembles 3 serial random bits into a candidate,
// rejects IDs already drawn from the current bag, falls back to the lowest
// unused ID after MAX_REJECTS misses, and offers the result on a valid/ready port.
module piece_bag_sampler
    import tetris_pkg::*;
#(
    parameter int MAX_REJECTS = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rand_bit,
    input  logic       flush,
    input  logic       piece_ready,
    output logic       piece_valid,
    output logic [2:0] piece_id,
    output logic [2:0] bag_remaining
);

    localparam int RJ_W = (MAX_REJECTS > 1) ? $clog2(MAX_REJECTS) : 1;

    state_t                r_state;
    logic [2:0]            r_cand;
    logic [1:0]            r_bit_cnt;
    logic [RJ_W-1:0]       r_reject_cnt;
    logic [NUM_PIECES-1:0] r_used_mask;
    piece_t                r_piece_id;

    logic [2:0]            w_fallback;
    logic [NUM_PIECES-1:0] w_cand_onehot;
    logic [NUM_PIECES-1:0] w_mask_next;
    logic                  w_cand_ok;
    logic [2:0]            w_popcnt;

    lowest_unused_picker u_picker (
        .i_used_mask (r_used_mask),
        .o_idx       (w_fallback)
    );

    // Candidate 7 shifts out of the 7-bit one-hot, so the explicit !=7 guard covers it
    assign w_cand_onehot = 7'b1 << r_cand;
    assign w_cand_ok     = (r_cand != 3'd7) && ((w_cand_onehot & r_used_mask) == '0);
    assign w_mask_next   = r_used_mask | (7'b1 << r_piece_id);

    // Count drawn pieces to report how many remain in the bag
    always_comb begin
        w_popcnt = '0;
        for (int unsigned i = 0; i < NUM_PIECES; i++) begin
            w_popcnt = w_popcnt + {2'b00, r_used_mask[i]};
        end
    end

    assign bag_remaining = 3'(NUM_PIECES) - w_popcnt;
    assign piece_valid   = (r_state == OFFER);
    assign piece_id      = r_piece_id;

    // Sampler FSM: collect bits, check candidate, hold offer until handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= COLLECT;
            r_cand       <= '0;
            r_bit_cnt    <= '0;
            r_reject_cnt <= '0;
            r_used_mask  <= '0;
            r_piece_id   <= I;
        end else if (flush) begin
            // Flush beats a simultaneous handshake: the offered piece is not recorded
            r_state      <= COLLECT;
            r_cand       <= '0;
            r_bit_cnt    <= '0;
            r_reject_cnt <= '0;
            r_used_mask  <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    r_cand    <= {r_cand[1:0], rand_bit};
                    r_bit_cnt <= r_bit_cnt + 2'd1;
                    if (r_bit_cnt == 2'd2) begin
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_cand_ok) begin
                        r_piece_id <= piece_t'(r_cand);
                        r_state    <= OFFER;
                    end else if (r_reject_cnt == RJ_W'(MAX_REJECTS - 1)) begin
                        r_piece_id <= piece_t'(w_fallback);
                        r_state    <= OFFER;
                    end else begin
                        r_reject_cnt <= r_reject_cnt + 1'b1;
                        r_bit_cnt    <= '0;
                        r_state      <= COLLECT;
                    end
                end
                OFFER: begin
                    if (piece_ready) begin
                        // The 7th draw of a bag wraps the mask straight back to empty
                        r_used_mask  <= (w_mask_next == '1) ? '0 : w_mask_next;
                        r_reject_cnt <= '0;
                        r_bit_cnt    <= '0;
                        r_state      <= COLLECT;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_piece_bag_sampler.sv
// Directed bench for piece_bag_sampler: reset, acceptance, fallback, bag
// permutation, rejection, offer stability, flush and mid-operation reset.
module tb_piece_bag_sampler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rand_bit;
    logic       flush;
    logic       piece_ready;
    logic       piece_valid;
    logic [2:0] piece_id;
    logic [2:0] bag_remaining;

    int checks = 0;
    int errors = 0;

    piece_bag_sampler #(.MAX_REJECTS(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rand_bit      (rand_bit),
        .flush         (flush),
        .piece_ready   (piece_ready),
        .piece_valid   (piece_valid),
        .piece_id      (piece_id),
        .bag_remaining (bag_remaining)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        rand_bit    = 1'b0;
        flush       = 1'b0;
        piece_ready = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Three serial bits (MSB first) followed by the CHECK cycle
    task automatic feed(input logic [2:0] b);
        for (int i = 2; i >= 0; i--) begin
            rand_bit = b[i];
            step();
        end
        rand_bit = 1'b0;
        step();
    endtask

    task automatic accept();
        piece_ready = 1'b1;
        step();
        piece_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        rand_bit    = 1'b0;
        flush       = 1'b0;
        piece_ready = 1'b0;
        step();
        checks++;
        if (piece_valid !== 1'b0 || piece_id !== 3'd0 || bag_remaining !== 3'd7) begin
            errors++;
            $display("FAIL reset: valid=%b id=%0d bag=%0d, required 0/0/7", piece_valid, piece_id, bag_remaining);
        end
        reset_n = 1'b1;
        rand_bit = 1'b0; step();
        rand_bit = 1'b1; step();
        rand_bit = 1'b1; step();
        checks++;
        if (piece_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_latency_early: valid=%b at cycle 3, required 0", piece_valid);
        end
        rand_bit = 1'b0; step();
        checks++;
        if (piece_valid !== 1'b1 || piece_id !== 3'd3 || bag_remaining !== 3'd7) begin
            errors++;
            $display("FAIL first_piece: valid=%b id=%0d bag=%0d, required 1/3/7", piece_valid, piece_id, bag_remaining);
        end
        accept();
        checks++;
        if (piece_valid !== 1'b0 || bag_remaining !== 3'd6) begin
            errors++;
            $display("FAIL first_accept: valid=%b bag=%0d, required 0/6", piece_valid, bag_remaining);
        end
    endtask

    task automatic test_fallback();
        int cnt;
        do_reset();
        rand_bit = 1'b1;
        cnt = 0;
        while (!piece_valid && cnt < 200) begin
            step();
            cnt++;
        end
        checks++;
        if (cnt !== 32 || piece_id !== 3'd0) begin
            errors++;
            $display("FAIL fallback_first: cycles=%0d id=%0d, required 32/0", cnt, piece_id);
        end
        accept();
        cnt = 0;
        while (!piece_valid && cnt < 200) begin
            step();
            cnt++;
        end
        checks++;
        if (cnt !== 32 || piece_id !== 3'd1 || bag_remaining !== 3'd6) begin
            errors++;
            $display("FAIL fallback_second: cycles=%0d id=%0d bag=%0d, required 32/1/6", cnt, piece_id, bag_remaining);
        end
        accept();
        rand_bit = 1'b0;
    endtask

    task automatic test_bag_permutation();
        int         cnt;
        int         k;
        logic [6:0] seen;
        do_reset();
        piece_ready = 1'b1;
        k = 0;
        seen = '0;
        for (int p = 0; p < 21; p++) begin
            cnt = 0;
            while (!piece_valid && cnt < 200) begin
                rand_bit = 1'($urandom_range(0, 1));
                step();
                cnt++;
            end
            checks++;
            if (!piece_valid) begin
                errors++;
                $display("FAIL bag_timeout: piece %0d not offered within %0d cycles", p, cnt);
            end
            checks++;
            if (bag_remaining !== 3'(7 - k)) begin
                errors++;
                $display("FAIL bag_remaining: piece %0d bag=%0d, required %0d", p, bag_remaining, 7 - k);
            end
            checks++;
            if (piece_id > 3'd6 || seen[piece_id[2:0] % 7] === 1'b1) begin
                errors++;
                $display("FAIL bag_perm: piece %0d id=%0d already drawn or invalid (seen=%b)", p, piece_id, seen);
            end
            if (piece_id <= 3'd6) seen[piece_id] = 1'b1;
            k++;
            step();
            checks++;
            if (piece_valid !== 1'b0) begin
                errors++;
                $display("FAIL bag_valid_drop: piece %0d valid=%b after handshake, required 0", p, piece_valid);
            end
            if (k == 7) begin
                checks++;
                if (bag_remaining !== 3'd7 || seen !== 7'h7F) begin
                    errors++;
                    $display("FAIL bag_wrap: bag=%0d seen=%b, required 7/1111111", bag_remaining, seen);
                end
                k = 0;
                seen = '0;
            end
        end
        piece_ready = 1'b0;
    endtask

    task automatic test_reject();
        do_reset();
        feed(3'b011);
        accept();
        feed(3'b011);
        checks++;
        if (piece_valid !== 1'b0 || bag_remaining !== 3'd6) begin
            errors++;
            $display("FAIL reject_used: valid=%b bag=%0d, required 0/6", piece_valid, bag_remaining);
        end
        feed(3'b101);
        checks++;
        if (piece_valid !== 1'b1 || piece_id !== 3'd5) begin
            errors++;
            $display("FAIL reject_then_accept: valid=%b id=%0d, required 1/5", piece_valid, piece_id);
        end
    endtask

    // Continues from test_reject with ID 5 on offer
    task automatic test_offer_hold();
        int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            rand_bit = i[0];
            step();
            checks++;
            if (piece_valid !== 1'b1 || piece_id !== 3'd5) begin
                errors++;
                bad++;
                $display("FAIL offer_hold: cycle %0d valid=%b id=%0d, required 1/5", i, piece_valid, piece_id);
            end
        end
        rand_bit = 1'b1;
        accept();
        rand_bit = 1'b1; step();
        rand_bit = 1'b1; step();
        checks++;
        if (piece_valid !== 1'b0) begin
            errors++;
            $display("FAIL offer_latency: valid=%b two bits after handshake, required 0", piece_valid);
        end
        rand_bit = 1'b0; step();
        checks++;
        if (piece_valid !== 1'b0) begin
            errors++;
            $display("FAIL offer_latency3: valid=%b three cycles after handshake, required 0", piece_valid);
        end
        step();
        checks++;
        if (piece_valid !== 1'b1 || piece_id !== 3'd6 || bag_remaining !== 3'd5) begin
            errors++;
            $display("FAIL post_offer_cand: valid=%b id=%0d bag=%0d, required 1/6/5", piece_valid, piece_id, bag_remaining);
        end
        accept();
    endtask

    task automatic test_flush_and_reset();
        do_reset();
        feed(3'b011);
        piece_ready = 1'b1;
        flush = 1'b1;
        step();
        piece_ready = 1'b0;
        flush = 1'b0;
        checks++;
        if (piece_valid !== 1'b0 || bag_remaining !== 3'd7) begin
            errors++;
            $display("FAIL flush_handshake: valid=%b bag=%0d, required 0/7", piece_valid, bag_remaining);
        end
        feed(3'b011);
        checks++;
        if (piece_valid !== 1'b1 || piece_id !== 3'd3) begin
            errors++;
            $display("FAIL flush_not_used: valid=%b id=%0d, required 1/3", piece_valid, piece_id);
        end
        accept();
        rand_bit = 1'b1;
        step();
        reset_n = 1'b0;
        #1;
        checks++;
        if (piece_valid !== 1'b0 || piece_id !== 3'd0 || bag_remaining !== 3'd7) begin
            errors++;
            $display("FAIL midreset: valid=%b id=%0d bag=%0d, required 0/0/7", piece_valid, piece_id, bag_remaining);
        end
        step();
        reset_n = 1'b1;
        feed(3'b100);
        checks++;
        if (piece_valid !== 1'b1 || piece_id !== 3'd4 || bag_remaining !== 3'd7) begin
            errors++;
            $display("FAIL after_midreset: valid=%b id=%0d bag=%0d, required 1/4/7", piece_valid, piece_id, bag_remaining);
        end
    endtask

    initial begin
        test_reset();
        test_fallback();
        test_bag_permutation();
        test_reject();
        test_offer_hold();
        test_flush_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
